// File: rtl/ul_bfp_packer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// ul_bfp_packer : packs BFP-compressed PRBs MSB-first into 64-bit words + FIFO
// Rev 1.0
// -----------------------------------------------------------------------------
module ul_bfp_packer #(
   parameter int NUM        = 7,
   parameter int FIFO_DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_sop,
   input  logic             i_eop,
   input  logic             i_vld,
   input  logic [2*NUM-1:0] i_dout,
   input  logic [3:0]       i_shift,
   input  logic [6:0]       i_slot_idx,
   input  logic [3:0]       i_symb_idx,
   input  logic [8:0]       i_prb_idx,
   output logic [63:0]      o_data,
   output logic             o_vld,
   input  logic             o_rdy,
   output logic             o_sop,
   output logic             o_eop,
   output logic [3:0]       o_bytes,
   output logic [6:0]       o_slot_idx,
   output logic [3:0]       o_symb_idx,
   output logic [8:0]       o_prb_idx,
   output logic             o_ovf_err,
   output logic             o_frm_err
);
   localparam int SW = 2 * NUM;
   localparam int HW = 8 + SW;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = 64 + 1 + 1 + 4 + 20;

   typedef enum logic [0:0] {IDLE = 1'b0, PACK = 1'b1} state_t;

   state_t          state;
   logic [127:0]    acc;
   logic [7:0]      cnt;
   logic            closing;
   logic            first_word;
   logic [19:0]     tags;
   logic            fl_vld;
   logic [EW-1:0]   fl_word;
   logic            frm_err;

   logic            start, frm_sop, discard, do_close, long_res;
   logic [7:0]      cnt_bytes;
   logic [3:0]      tail_bytes;
   logic            acc_emit, tail_load;
   logic [EW-1:0]   acc_word, tail_word;
   logic [127:0]    base, ins;
   logic [7:0]      base_cnt;
   logic            wr_req;
   logic [EW-1:0]   wr_word;

   assign start      = i_vld && i_sop;
   assign frm_sop    = start && (state == PACK);
   assign discard    = i_vld && !i_sop && (state == IDLE);
   // A sop inside a PRB closes the running PRB in the same cycle as an eop would have
   assign do_close   = closing || frm_sop;
   assign long_res   = cnt > 8'd64;
   assign cnt_bytes  = (cnt + 8'd7) >> 3;
   assign tail_bytes = 4'(cnt_bytes - 8'd8);

   always_comb begin
      acc_emit  = 1'b0;
      acc_word  = '0;
      tail_load = 1'b0;
      tail_word = '0;
      if (do_close) begin
         acc_emit  = (cnt != 8'd0);
         acc_word  = {acc[127:64], first_word, !long_res, long_res ? 4'd8 : cnt_bytes[3:0], tags};
         tail_load = long_res;
         tail_word = {acc[63:0], 1'b0, 1'b1, tail_bytes, tags};
      end else if (cnt >= 8'd64 && !fl_vld) begin
         acc_emit = 1'b1;
         acc_word = {acc[127:64], first_word, 1'b0, 4'd8, tags};
      end
   end

   always_comb begin
      base     = acc;
      base_cnt = cnt;
      if (do_close) begin
         base     = '0;
         base_cnt = 8'd0;
      end else if (acc_emit) begin
         base     = {acc[63:0], 64'b0};
         base_cnt = cnt - 8'd64;
      end
   end

   assign ins = {i_dout, {(128-SW){1'b0}}} >> base_cnt;

   // The staged tail always goes out first; a PRB closing behind it takes its place
   assign wr_req  = fl_vld || acc_emit;
   assign wr_word = fl_vld ? fl_word : acc_word;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         acc        <= '0;
         cnt        <= 8'd0;
         closing    <= 1'b0;
         first_word <= 1'b0;
         tags       <= '0;
         fl_vld     <= 1'b0;
         fl_word    <= '0;
         frm_err    <= 1'b0;
      end else begin
         acc     <= base;
         cnt     <= base_cnt;
         closing <= 1'b0;
         if (acc_emit)
            first_word <= 1'b0;
         fl_vld <= (fl_vld && acc_emit) || tail_load;
         if (fl_vld)
            fl_word <= acc_word;
         else if (tail_load)
            fl_word <= tail_word;
         if (start) begin
            acc        <= {4'b0000, i_shift, i_dout, {(128-HW){1'b0}}};
            cnt        <= 8'(HW);
            first_word <= 1'b1;
            tags       <= {i_slot_idx, i_symb_idx, i_prb_idx};
            state      <= i_eop ? IDLE : PACK;
            closing    <= i_eop;
         end else if (i_vld && state == PACK) begin
            acc <= base | ins;
            cnt <= base_cnt + 8'(SW);
            if (i_eop) begin
               state   <= IDLE;
               closing <= 1'b1;
            end
         end
         if (frm_sop || discard)
            frm_err <= 1'b1;
      end
   end

   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr;
   logic          empty, full, rd, wr_ok, ovf_err;
   logic [EW-1:0] head;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd    = !empty && o_rdy;
   assign wr_ok = wr_req && (!full || rd);
   assign head  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[wr_ptr[AW-1:0]] <= wr_word;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         ovf_err <= 1'b0;
      end else begin
         if (wr_ok)
            wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
         if (rd)
            rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
         if (wr_req && full && !rd)
            ovf_err <= 1'b1;
      end
   end

   assign o_vld = !empty;
   assign {o_data, o_sop, o_eop, o_bytes, o_slot_idx, o_symb_idx, o_prb_idx} = o_vld ? head : '0;
   assign o_ovf_err = ovf_err;
   assign o_frm_err = frm_err;

endmodule
`default_nettype wire

// File: tb/tb_ul_bfp_packer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_ul_bfp_packer : directed self-checking bench for ul_bfp_packer (NUM=7)
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_ul_bfp_packer;
   localparam int NUM = 7;
   localparam int SW  = 2 * NUM;
   localparam logic [63:0] W0 = 64'h0300_0000_1000_8003;
   localparam logic [63:0] W1 = 64'h0010_0050_0180_0700;
   localparam logic [63:0] W2 = 64'h2000_9002_800B_0000;
   localparam logic [19:0] TG1 = {7'd11, 4'd2, 9'd33};
   localparam logic [19:0] TGA = {7'd5, 4'd7, 9'd100};
   localparam logic [19:0] TGB = {7'd6, 4'd8, 9'd273};

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_sop = 1'b0, i_eop = 1'b0, i_vld = 1'b0;
   logic [SW-1:0] i_dout = '0;
   logic [3:0]    i_shift = '0;
   logic [6:0]    i_slot_idx = '0;
   logic [3:0]    i_symb_idx = '0;
   logic [8:0]    i_prb_idx = '0;
   logic [63:0]   o_data;
   logic          o_vld, o_rdy = 1'b1, o_sop, o_eop, o_ovf_err, o_frm_err;
   logic [3:0]    o_bytes;
   logic [6:0]    o_slot_idx;
   logic [3:0]    o_symb_idx;
   logic [8:0]    o_prb_idx;

   typedef struct packed {
      logic [63:0] data;
      logic        sop;
      logic        eop;
      logic [3:0]  bytes;
      logic [19:0] tags;
   } word_t;

   word_t got[$];
   word_t exp_q[$];
   int    passed = 0;
   int    total  = 0;

   ul_bfp_packer #(.NUM(NUM), .FIFO_DEPTH(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_sop(i_sop), .i_eop(i_eop), .i_vld(i_vld), .i_dout(i_dout), .i_shift(i_shift),
      .i_slot_idx(i_slot_idx), .i_symb_idx(i_symb_idx), .i_prb_idx(i_prb_idx),
      .o_data(o_data), .o_vld(o_vld), .o_rdy(o_rdy), .o_sop(o_sop), .o_eop(o_eop),
      .o_bytes(o_bytes), .o_slot_idx(o_slot_idx), .o_symb_idx(o_symb_idx),
      .o_prb_idx(o_prb_idx), .o_ovf_err(o_ovf_err), .o_frm_err(o_frm_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (rst_n && o_vld && o_rdy)
         got.push_back({o_data, o_sop, o_eop, o_bytes, o_slot_idx, o_symb_idx, o_prb_idx});

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic s, input logic e, input logic [SW-1:0] d,
                        input logic [3:0] sh, input logic [19:0] tg);
      i_vld = v; i_sop = s; i_eop = e; i_dout = d; i_shift = sh;
      {i_slot_idx, i_symb_idx, i_prb_idx} = tg;
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, 4'd0, 20'd0);
   endtask

   task automatic send_prb(input logic [3:0] sh, input int n, input int base,
                           input logic [19:0] tg, input bit with_eop);
      for (int k = 0; k < n; k++)
         drive(1'b1, k == 0, with_eop && (k == n - 1), SW'(base + k), sh, tg);
   endtask

   // Reference bitstream: header byte then samples, cut into 64-bit words
   task automatic model_prb(input logic [3:0] sh, input int n, input int base, input logic [19:0] tg);
      logic [511:0] bits;
      logic [SW-1:0] s;
      int len;
      word_t w;
      bits = '0;
      bits[511 -: 8] = {4'b0000, sh};
      len = 8;
      for (int k = 0; k < n; k++) begin
         s = SW'(base + k);
         bits[511 - len -: SW] = s;
         len += SW;
      end
      for (int i = 0; i * 64 < len; i++) begin
         w.data  = bits[511 - 64 * i -: 64];
         w.sop   = (i == 0);
         w.eop   = ((i + 1) * 64 >= len);
         w.bytes = w.eop ? 4'((len - 64 * i + 7) / 8) : 4'd8;
         w.tags  = tg;
         exp_q.push_back(w);
      end
   endtask

   task automatic apply_reset();
      i_vld = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      got.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; o_rdy = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++; if (o_vld !== 1'b0) $display("FAIL reset_vld: got %b want 0", o_vld); else passed++;
      total++; if (o_data !== 64'd0) $display("FAIL reset_data: got %h want 0", o_data); else passed++;
      total++; if ({o_sop, o_eop, o_bytes} !== 6'd0) $display("FAIL reset_flags: got %b want 0", {o_sop, o_eop, o_bytes}); else passed++;
      total++; if ({o_ovf_err, o_frm_err} !== 2'b00) $display("FAIL reset_err: got %b want 00", {o_ovf_err, o_frm_err}); else passed++;
      rst_n = 1'b1;
      tick();
      total++; if (o_vld !== 1'b0) $display("FAIL reset_release_vld: got %b want 0", o_vld); else passed++;
   endtask

   task automatic test_single_prb();
      apply_reset();
      o_rdy = 1'b1;
      for (int k = 0; k < 12; k++) begin
         drive(1'b1, k == 0, k == 11, SW'(k), 4'd3, TG1);
         if (k == 3) begin
            total++; if (o_vld !== 1'b0) $display("FAIL latency_early: got o_vld %b want 0", o_vld); else passed++;
         end
         if (k == 4) begin
            total++; if (o_vld !== 1'b1 || o_data !== W0)
               $display("FAIL latency_word0: got vld %b data %h want 1 %h", o_vld, o_data, W0); else passed++;
         end
      end
      idle(8);
      total++; if (got.size() !== 3) $display("FAIL single_count: got %0d want 3", got.size()); else passed++;
      if (got.size() == 3) begin
         total++; if (got[0].data !== W0 || got[0].sop !== 1'b1 || got[0].bytes !== 4'd8)
            $display("FAIL single_w0: got %h sop %b bytes %0d want %h 1 8", got[0].data, got[0].sop, got[0].bytes, W0); else passed++;
         total++; if (got[1].data !== W1 || got[1].sop !== 1'b0 || got[1].eop !== 1'b0)
            $display("FAIL single_w1: got %h sop %b eop %b want %h 0 0", got[1].data, got[1].sop, got[1].eop, W1); else passed++;
         total++; if (got[2].data !== W2 || got[2].eop !== 1'b1 || got[2].bytes !== 4'd6)
            $display("FAIL single_w2: got %h eop %b bytes %0d want %h 1 6", got[2].data, got[2].eop, got[2].bytes, W2); else passed++;
         total++; if (got[2].tags !== TG1) $display("FAIL single_tags: got %h want %h", got[2].tags, TG1); else passed++;
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      o_rdy = 1'b1;
      send_prb(4'd5, 12, 100, TGA, 1'b1);
      send_prb(4'd9, 12, 200, TGB, 1'b1);
      idle(8);
      model_prb(4'd5, 12, 100, TGA);
      model_prb(4'd9, 12, 200, TGB);
      total++; if (got.size() !== 6) $display("FAIL b2b_count: got %0d want 6", got.size()); else passed++;
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         total++; if (got[i] !== exp_q[i]) $display("FAIL b2b_word%0d: got %h want %h", i, got[i], exp_q[i]); else passed++;
      end
      if (got.size() >= 4) begin
         total++; if (got[3].data[63:56] !== 8'h09 || got[3].sop !== 1'b1 || got[3].tags !== TGB || got[2].tags !== TGA)
            $display("FAIL b2b_switch: got hdr %h sop %b tags %h/%h want 09 1 %h/%h",
                     got[3].data[63:56], got[3].sop, got[2].tags, got[3].tags, TGA, TGB); else passed++;
      end
      total++; if ({o_ovf_err, o_frm_err} !== 2'b00) $display("FAIL b2b_err: got %b want 00", {o_ovf_err, o_frm_err}); else passed++;
   endtask

   task automatic test_flush_tail();
      apply_reset();
      o_rdy = 1'b1;
      send_prb(4'd1, 9, 300, TGA, 1'b1);
      send_prb(4'd2, 12, 400, TGB, 1'b1);
      idle(8);
      model_prb(4'd1, 9, 300, TGA);
      model_prb(4'd2, 12, 400, TGB);
      total++; if (got.size() !== 6) $display("FAIL tail_count: got %0d want 6", got.size()); else passed++;
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         total++; if (got[i] !== exp_q[i]) $display("FAIL tail_word%0d: got %h want %h", i, got[i], exp_q[i]); else passed++;
      end
   endtask

   task automatic test_odd_count();
      apply_reset();
      o_rdy = 1'b1;
      send_prb(4'd2, 3, 14'h1555, TG1, 1'b1);
      idle(6);
      model_prb(4'd2, 3, 14'h1555, TG1);
      total++; if (got.size() !== 1) $display("FAIL odd_count: got %0d want 1", got.size()); else passed++;
      if (got.size() == 1) begin
         total++; if (got[0] !== exp_q[0]) $display("FAIL odd_word: got %h want %h", got[0], exp_q[0]); else passed++;
         total++; if (got[0].bytes !== 4'd7 || got[0].data[5:0] !== 6'd0 || got[0].sop !== 1'b1 || got[0].eop !== 1'b1)
            $display("FAIL odd_flags: got bytes %0d low %h sop %b eop %b want 7 0 1 1",
                     got[0].bytes, got[0].data[5:0], got[0].sop, got[0].eop); else passed++;
      end
   endtask

   task automatic test_overflow();
      apply_reset();
      o_rdy = 1'b0;
      for (int p = 0; p < 12; p++) begin
         send_prb(4'(p), 12, p * 16, {7'(p), 4'(p), 9'(p + 100)}, 1'b1);
         model_prb(4'(p), 12, p * 16, {7'(p), 4'(p), 9'(p + 100)});
         if (p == 4) begin
            total++; if (o_ovf_err !== 1'b0) $display("FAIL ovf_early: got %b want 0", o_ovf_err); else passed++;
         end
      end
      idle(4);
      total++; if (o_ovf_err !== 1'b1) $display("FAIL ovf_set: got %b want 1", o_ovf_err); else passed++;
      total++; if (got.size() !== 0) $display("FAIL ovf_stall: got %0d words while stalled want 0", got.size()); else passed++;
      o_rdy = 1'b1;
      idle(24);
      total++; if (got.size() !== 16) $display("FAIL ovf_drain_count: got %0d want 16", got.size()); else passed++;
      for (int i = 0; i < 16 && i < got.size(); i++) begin
         total++; if (got[i] !== exp_q[i]) $display("FAIL ovf_word%0d: got %h want %h", i, got[i], exp_q[i]); else passed++;
      end
      total++; if ({o_ovf_err, o_frm_err} !== 2'b10) $display("FAIL ovf_sticky: got %b want 10", {o_ovf_err, o_frm_err}); else passed++;
   endtask

   task automatic test_framing();
      apply_reset();
      o_rdy = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 14'h3FFF, 4'd4, TG1);
      idle(4);
      total++; if (o_frm_err !== 1'b1) $display("FAIL frm_stray: got %b want 1", o_frm_err); else passed++;
      total++; if (got.size() !== 0) $display("FAIL frm_stray_out: got %0d words want 0", got.size()); else passed++;
      apply_reset();
      send_prb(4'd6, 5, 30, TGA, 1'b0);
      send_prb(4'd7, 12, 50, TGB, 1'b1);
      idle(8);
      model_prb(4'd6, 5, 30, TGA);
      model_prb(4'd7, 12, 50, TGB);
      total++; if (got.size() !== 5) $display("FAIL frm_count: got %0d want 5", got.size()); else passed++;
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         total++; if (got[i] !== exp_q[i]) $display("FAIL frm_word%0d: got %h want %h", i, got[i], exp_q[i]); else passed++;
      end
      if (got.size() >= 2) begin
         total++; if (got[1].bytes !== 4'd2 || got[1].eop !== 1'b1)
            $display("FAIL frm_cut: got bytes %0d eop %b want 2 1", got[1].bytes, got[1].eop); else passed++;
      end
      total++; if (o_frm_err !== 1'b1) $display("FAIL frm_sop_err: got %b want 1", o_frm_err); else passed++;
   endtask

   task automatic test_async_reset();
      apply_reset();
      o_rdy = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 14'h0001, 4'd3, TG1);
      send_prb(4'd3, 8, 0, TG1, 1'b0);
      i_vld = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
      total++; if (o_vld !== 1'b1 || o_frm_err !== 1'b1)
         $display("FAIL arst_pre: got vld %b frm %b want 1 1", o_vld, o_frm_err); else passed++;
      #2 rst_n = 1'b0;
      #1;
      total++; if (o_vld !== 1'b0 || o_data !== 64'd0)
         $display("FAIL arst_vld: got vld %b data %h want 0 0", o_vld, o_data); else passed++;
      total++; if ({o_ovf_err, o_frm_err} !== 2'b00) $display("FAIL arst_err: got %b want 00", {o_ovf_err, o_frm_err}); else passed++;
      tick();
      rst_n = 1'b1;
      tick();
      got.delete();
      o_rdy = 1'b1;
      send_prb(4'd3, 12, 0, TG1, 1'b1);
      idle(8);
      total++; if (got.size() !== 3) $display("FAIL arst_count: got %0d want 3", got.size()); else passed++;
      if (got.size() == 3) begin
         total++; if (got[0].data !== W0 || got[1].data !== W1 || got[2].data !== W2)
            $display("FAIL arst_data: got %h %h %h want %h %h %h", got[0].data, got[1].data, got[2].data, W0, W1, W2); else passed++;
         total++; if (got[0].sop !== 1'b1 || got[2].eop !== 1'b1 || got[2].bytes !== 4'd6)
            $display("FAIL arst_flags: got sop %b eop %b bytes %0d want 1 1 6", got[0].sop, got[2].eop, got[2].bytes); else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_single_prb();
      test_back_to_back();
      test_flush_tail();
      test_odd_count();
      test_overflow();
      test_framing();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", passed, total);
      $fatal(1);
   end

endmodule
`default_nettype wire
